// File: rtl/denoise_frame_ctrl.sv
// denoise_frame_ctrl: frame-level controller for the 5x5 denoise kernel.
// Double-buffers kernel config so changes land only on a vsync boundary, accumulates a
// bounding box and mask-pixel count per frame, and publishes per-frame results.
// Optional feature macro: AUTO_THRESH_EN (auto-adjust threshold from the frame pixel count).
module denoise_frame_ctrl #(
    parameter int unsigned COORD_W    = 13,
    parameter int unsigned CNT_W      = 20,
    parameter int unsigned MIN_PIXELS = 16,
    parameter int unsigned HI_PIXELS  = 20000,
    parameter int unsigned DEF_THRESH = 13,
    parameter int unsigned MAX_THRESH = 25
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               vs_ni,
    input  logic               valid_i,
    input  logic               out_img_i,
    input  logic [COORD_W-1:0] row_i,
    input  logic [COORD_W-1:0] col_i,
    input  logic               cfg_wr,
    input  logic [4:0]         cfg_threshold,
    input  logic               cfg_filter_en,
    input  logic               cfg_rect_en,
    output logic [4:0]         threshold_o,
    output logic               filter_en_o,
    output logic               rect_en_o,
    output logic [COORD_W-1:0] top_o,
    output logic [COORD_W-1:0] bot_o,
    output logic [COORD_W-1:0] left_o,
    output logic [COORD_W-1:0] right_o,
    output logic               box_valid_o,
    output logic [CNT_W-1:0]   pix_count_o,
    output logic               frame_done_o,
    output logic [15:0]        frame_cnt_o
);

    typedef enum logic [1:0] {StWait, StSync, StActive, StCommit} state_e;

    state_e             state;
    logic               vs_q;
    logic               boundary;
    logic               pix_hit;
    logic               box_ok;
    logic [4:0]         sh_thresh;
    logic               sh_filter;
    logic               sh_rect;
    logic               pending;
    logic [CNT_W-1:0]   count;
    logic [COORD_W-1:0] min_row;
    logic [COORD_W-1:0] max_row;
    logic [COORD_W-1:0] min_col;
    logic [COORD_W-1:0] max_col;
    logic [4:0]         auto_thresh;

    // Boundary detection, accumulate qualifier and box-valid decision.
    always_comb begin
        boundary = vs_q & ~vs_ni;
        pix_hit  = (state == StActive) & valid_i & out_img_i & rect_en_o & ~boundary;
        box_ok   = (count >= CNT_W'(MIN_PIXELS));
    end

`ifdef AUTO_THRESH_EN
    // Threshold to use at a commit with no pending config: nudge toward a sane pixel count.
    always_comb begin
        auto_thresh = threshold_o;
        if (count > CNT_W'(HI_PIXELS)) begin
            if (threshold_o < 5'(MAX_THRESH)) auto_thresh = threshold_o + 5'd1;
        end else if (count < CNT_W'(MIN_PIXELS)) begin
            if (threshold_o != 5'd0) auto_thresh = threshold_o - 5'd1;
        end
    end
`else
    // Without auto-adjust the threshold simply holds across commits.
    always_comb begin
        auto_thresh = threshold_o;
    end

    logic unused_auto_params;
    assign unused_auto_params = (HI_PIXELS > MAX_THRESH);
`endif

    // Frame FSM with registered outputs, config shadowing and box/count accumulation.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= StWait;
            vs_q         <= 1'b1;
            sh_thresh    <= 5'(DEF_THRESH);
            sh_filter    <= 1'b0;
            sh_rect      <= 1'b0;
            pending      <= 1'b0;
            count        <= '0;
            min_row      <= '1;
            max_row      <= '0;
            min_col      <= '1;
            max_col      <= '0;
            threshold_o  <= 5'(DEF_THRESH);
            filter_en_o  <= 1'b0;
            rect_en_o    <= 1'b0;
            top_o        <= '0;
            bot_o        <= '0;
            left_o       <= '0;
            right_o      <= '0;
            box_valid_o  <= 1'b0;
            pix_count_o  <= '0;
            frame_done_o <= 1'b0;
            frame_cnt_o  <= '0;
        end else begin
            vs_q         <= vs_ni;
            frame_done_o <= 1'b0;
            case (state)
                StWait: begin
                    // First boundary only aligns us; the partial frame before it is dropped.
                    if (boundary) begin
                        if (pending) begin
                            threshold_o <= sh_thresh;
                            filter_en_o <= sh_filter;
                            rect_en_o   <= sh_rect;
                        end
                        pending <= 1'b0;
                        count   <= '0;
                        min_row <= '1;
                        max_row <= '0;
                        min_col <= '1;
                        max_col <= '0;
                        state   <= StSync;
                    end
                end
                StSync: begin
                    if (vs_ni) state <= StActive;
                end
                StActive: begin
                    if (boundary) begin
                        pix_count_o  <= count;
                        box_valid_o  <= box_ok;
                        if (box_ok) begin
                            top_o   <= min_row;
                            bot_o   <= max_row;
                            left_o  <= min_col;
                            right_o <= max_col;
                        end
                        frame_cnt_o  <= frame_cnt_o + 16'd1;
                        frame_done_o <= 1'b1;
                        if (pending) begin
                            threshold_o <= sh_thresh;
                            filter_en_o <= sh_filter;
                            rect_en_o   <= sh_rect;
                        end else begin
                            threshold_o <= auto_thresh;
                        end
                        pending <= 1'b0;
                        count   <= '0;
                        min_row <= '1;
                        max_row <= '0;
                        min_col <= '1;
                        max_col <= '0;
                        state   <= StCommit;
                    end else if (pix_hit) begin
                        if (count != '1) count <= count + CNT_W'(1);
                        if (row_i < min_row) min_row <= row_i;
                        if (row_i > max_row) max_row <= row_i;
                        if (col_i < min_col) min_col <= col_i;
                        if (col_i > max_col) max_col <= col_i;
                    end
                end
                StCommit: begin
                    state <= StSync;
                end
                default: begin
                    state <= StWait;
                end
            endcase
            // Placed after the boundary logic so a write in the edge cycle stays pending.
            if (cfg_wr) begin
                sh_thresh <= cfg_threshold;
                sh_filter <= cfg_filter_en;
                sh_rect   <= cfg_rect_en;
                pending   <= 1'b1;
            end
        end
    end

endmodule
